// File: rtl/toy_bus_dtcm_arb2_if.sv
// One ToyBus link: request channel (master -> slave) and ack channel (slave -> master).
// The arbiter is a slave to each upstream master and a master towards the DTCM node.
interface toy_bus_dtcm_arb2_if;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic        req_opcode;
  logic [3:0]  req_src_id;
  logic [3:0]  req_tgt_id;
  logic        ack_vld;
  logic        ack_rdy;
  logic [31:0] ack_data;
  logic        ack_opcode;
  logic [3:0]  ack_src_id;
  logic [3:0]  ack_tgt_id;

  modport master (
    output req_vld, req_addr, req_data, req_strb, req_opcode, req_src_id, req_tgt_id,
    output ack_rdy,
    input  req_rdy,
    input  ack_vld, ack_data, ack_opcode, ack_src_id, ack_tgt_id
  );

  modport slave (
    input  req_vld, req_addr, req_data, req_strb, req_opcode, req_src_id, req_tgt_id,
    input  ack_rdy,
    output req_rdy,
    output ack_vld, ack_data, ack_opcode, ack_src_id, ack_tgt_id
  );
endinterface

// File: rtl/toy_bus_dtcm_arb2.sv
// Two-master round-robin request arbiter in front of the DTCM node, with a per-master
// response FIFO; reads are only issued when the owning FIFO is guaranteed a free slot.
module toy_bus_dtcm_arb2 #(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  toy_bus_dtcm_arb2_if.slave        in0,
  toy_bus_dtcm_arb2_if.slave        in1,
  toy_bus_dtcm_arb2_if.master       out0,
  output logic                      err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW:0] DepthLimit = (OW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  srcId;
    logic [3:0]  tgtId;
  } ackEntry_t;

  logic [1:0]  reqVld;
  logic [1:0]  reqOpcode;
  logic [1:0]  ackRdy;
  logic [31:0] reqAddr  [2];
  logic [31:0] reqData  [2];
  logic [3:0]  reqStrb  [2];
  logic [3:0]  reqSrcId [2];
  logic [3:0]  reqTgtId [2];

  logic lastGrant_q, lastGrant_d;
  logic lockVld_q, lockVld_d;
  logic lockId_q, lockId_d;
  logic inflVld_q, inflVld_d;
  logic inflId_q, inflId_d;
  logic err_q, err_d;

  logic [OW-1:0] occ_q   [2];
  logic [OW-1:0] occ_d   [2];
  logic [AW-1:0] wrPtr_q [2];
  logic [AW-1:0] wrPtr_d [2];
  logic [AW-1:0] rdPtr_q [2];
  logic [AW-1:0] rdPtr_d [2];
  ackEntry_t     mem_q   [2][DEPTH];
  ackEntry_t     ackHead [2];

  logic [1:0] credit;
  logic [1:0] elig;
  logic [1:0] push;
  logic [1:0] pop;
  logic       grantVld;
  logic       grantId;
  logic       handshake;
  ackEntry_t  ackIn;
  logic       unusedAckOpcode;

  assign reqVld      = {in1.req_vld, in0.req_vld};
  assign reqOpcode   = {in1.req_opcode, in0.req_opcode};
  assign ackRdy      = {in1.ack_rdy, in0.ack_rdy};
  assign reqAddr[0]  = in0.req_addr;
  assign reqAddr[1]  = in1.req_addr;
  assign reqData[0]  = in0.req_data;
  assign reqData[1]  = in1.req_data;
  assign reqStrb[0]  = in0.req_strb;
  assign reqStrb[1]  = in1.req_strb;
  assign reqSrcId[0] = in0.req_src_id;
  assign reqSrcId[1] = in1.req_src_id;
  assign reqTgtId[0] = in0.req_tgt_id;
  assign reqTgtId[1] = in1.req_tgt_id;

  assign unusedAckOpcode = out0.ack_opcode;

  // A slot is reserved for the read whose ack is still on the wire; a pop this cycle does not free credit.
  always_comb begin
    credit = '0;
    elig   = '0;
    for (int i = 0; i < 2; i++) begin
      credit[i] = ({1'b0, occ_q[i]} + {{OW{1'b0}}, (inflVld_q && (inflId_q == 1'(i)))}) < DepthLimit;
      elig[i]   = !rst && reqVld[i] && (reqOpcode[i] || credit[i]);
    end
  end

  always_comb begin
    grantVld = |elig;
    grantId  = 1'b0;
    if (lockVld_q && elig[lockId_q]) begin
      grantId = lockId_q;
    end else if (elig[0] && elig[1]) begin
      grantId = ~lastGrant_q;
    end else begin
      grantId = elig[1];
    end
  end

  assign handshake = grantVld && out0.req_rdy;

  assign out0.req_vld    = grantVld;
  assign out0.req_addr   = reqAddr[grantId];
  assign out0.req_data   = reqData[grantId];
  assign out0.req_strb   = reqStrb[grantId];
  assign out0.req_opcode = reqOpcode[grantId];
  assign out0.req_src_id = reqSrcId[grantId];
  assign out0.req_tgt_id = reqTgtId[grantId];
  assign out0.ack_rdy    = 1'b1;

  assign in0.req_rdy = handshake && (grantId == 1'b0);
  assign in1.req_rdy = handshake && (grantId == 1'b1);

  always_comb begin
    lastGrant_d = lastGrant_q;
    lockVld_d   = grantVld && !out0.req_rdy;
    lockId_d    = grantId;
    inflVld_d   = handshake && !reqOpcode[grantId];
    inflId_d    = grantId;
    err_d       = err_q;
    if (handshake) begin
      lastGrant_d = grantId;
    end
    // The node answers every read exactly one cycle later, so any mismatch is a protocol error.
    if (out0.ack_vld != inflVld_q) begin
      err_d = 1'b1;
    end
  end

  assign ackIn = '{data: out0.ack_data, srcId: out0.ack_src_id, tgtId: out0.ack_tgt_id};

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < 2; i++) begin
      push[i]    = out0.ack_vld && inflVld_q && (inflId_q == 1'(i));
      pop[i]     = (occ_q[i] != '0) && ackRdy[i];
      occ_d[i]   = occ_q[i] + OW'(push[i]) - OW'(pop[i]);
      wrPtr_d[i] = wrPtr_q[i] + AW'(push[i]);
      rdPtr_d[i] = rdPtr_q[i] + AW'(pop[i]);
      ackHead[i] = mem_q[i][rdPtr_q[i]];
    end
  end

  assign in0.ack_vld    = (occ_q[0] != '0);
  assign in0.ack_data   = ackHead[0].data;
  assign in0.ack_src_id = ackHead[0].srcId;
  assign in0.ack_tgt_id = ackHead[0].tgtId;
  assign in0.ack_opcode = 1'b0;
  assign in1.ack_vld    = (occ_q[1] != '0);
  assign in1.ack_data   = ackHead[1].data;
  assign in1.ack_src_id = ackHead[1].srcId;
  assign in1.ack_tgt_id = ackHead[1].tgtId;
  assign in1.ack_opcode = 1'b0;

  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
      lockVld_q   <= 1'b0;
      lockId_q    <= 1'b0;
      inflVld_q   <= 1'b0;
      inflId_q    <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        occ_q[i]   <= '0;
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
      end
    end else begin
      lastGrant_q <= lastGrant_d;
      lockVld_q   <= lockVld_d;
      lockId_q    <= lockId_d;
      inflVld_q   <= inflVld_d;
      inflId_q    <= inflId_d;
      err_q       <= err_d;
      for (int i = 0; i < 2; i++) begin
        occ_q[i]   <= occ_d[i];
        wrPtr_q[i] <= wrPtr_d[i];
        rdPtr_q[i] <= rdPtr_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i] && !rst) begin
        mem_q[i][wrPtr_q[i]] <= ackIn;
      end
    end
  end

endmodule
